// File: rtl/mem_arb.sv
// mem_arb: shares one single-ported memory between the fetch and data requesters.
// Optional MEM_ARB_RR_EN selects round-robin on contention (default: data always wins).
module mem_arb (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_vld,
  output logic [31:0] o_if_rdata,
  output logic        o_if_stall,
  input  logic        i_dm_req,
  input  logic        i_dm_wen,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_mask,
  output logic        o_dm_gnt,
  output logic        o_dm_vld,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_stall,
  output logic        o_mem_req,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvld,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IF_RD = 2'd1;
  localparam logic [1:0] DM_RD = 2'd2;

  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  logic [1:0]    state_q, state_d;
  logic          if_vld_q, if_vld_d;
  logic          dm_vld_q, dm_vld_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  logic          if_win;
  logic          arb_open;
  logic          accept;

`ifdef MEM_ARB_RR_EN
  // Pointer: 0 = data side preferred, 1 = fetch side preferred.
  logic          ptr_q, ptr_d;
  logic          contend;

  assign contend = i_if_req && i_dm_req;
  assign if_win  = i_if_req && (!i_dm_req || ptr_q);
`else
  assign if_win  = i_if_req && !i_dm_req;
`endif

  // Arbitration reopens only once the response pulse has been presented.
  assign arb_open  = !i_rst && (state_q == IDLE) && !if_vld_q && !dm_vld_q;
  assign o_mem_req = arb_open && (i_if_req || i_dm_req);
  assign accept    = o_mem_req && i_mem_ready;
  assign o_if_gnt  = accept && if_win;
  assign o_dm_gnt  = accept && !if_win;

  assign o_mem_wen   = if_win ? 1'b0 : i_dm_wen;
  assign o_mem_addr  = (if_win ? i_if_addr : i_dm_addr) & WORD_MASK;
  assign o_mem_wdata = if_win ? DW'(0) : i_dm_wdata;
  assign o_mem_mask  = if_win ? {MW{1'b1}} : i_dm_mask;

  // Stall spans request through response; the owning read state covers a dropped request.
  assign o_if_stall = (state_q == IF_RD) || (i_if_req && !if_vld_q);
  assign o_dm_stall = (state_q == DM_RD) ||
                      (i_dm_req && !dm_vld_q && !(o_dm_gnt && i_dm_wen));

  assign o_if_vld   = if_vld_q;
  assign o_dm_vld   = dm_vld_q;
  assign o_if_rdata = if_rdata_q;
  assign o_dm_rdata = dm_rdata_q;

  always_comb begin
    state_d    = state_q;
    if_vld_d   = 1'b0;
    dm_vld_d   = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
`ifdef MEM_ARB_RR_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (if_win) begin
            state_d = IF_RD;
          end else if (!i_dm_wen) begin
            state_d = DM_RD;
          end
`ifdef MEM_ARB_RR_EN
          if (contend) begin
            ptr_d = !if_win;
          end
`endif
        end
      end
      IF_RD: begin
        if (i_mem_rvld) begin
          if_rdata_d = i_mem_rdata;
          if_vld_d   = 1'b1;
          state_d    = IDLE;
        end
      end
      DM_RD: begin
        if (i_mem_rvld) begin
          dm_rdata_d = i_mem_rdata;
          dm_vld_d   = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      if_vld_q   <= 1'b0;
      dm_vld_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      if_vld_q   <= if_vld_d;
      dm_vld_q   <= dm_vld_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule
